// File: rtl/aes_bram_pkg.sv
// Shared definitions for the AES BRAM block reader and its future writer counterpart.
// State encodings are plain constants so legacy code can compare them numerically.
package aes_bram_pkg;

  localparam int WORD_W              = 32;
  localparam int BLOCK_W             = 128;
  localparam int DEFAULT_ADDR_STRIDE = 4;

  typedef logic [2:0]        state_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_REQ   = 3'd1;
  localparam state_t ST_REL   = 3'd2;
  localparam state_t ST_DONE  = 3'd3;
  localparam state_t ST_ABORT = 3'd4;

endpackage

// File: rtl/aes_bram_block_reader_watchdog.sv
// Handshake watchdog: up-counter cleared on every phase entry, flags the last allowed cycle.
module bram_hs_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic axi_clk,
  input  logic axi_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Expired on the cycle that would complete TIMEOUT_CYCLES cycles in the current phase.
  assign expired = enable && (count >= CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/aes_bram_block_reader.sv
// Fetches WORDS_PER_BLOCK words over the four-phase BRAM read handshake and
// hands the assembled AES block downstream on a valid/ready interface.
module aes_bram_block_reader
  import aes_bram_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int ADDR_STRIDE     = DEFAULT_ADDR_STRIDE,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic                              axi_clk,
  input  logic                              axi_rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [31:0]                       cmd_base_addr,
  output logic                              bram_start_read,
  output logic [31:0]                       bram_addr,
  input  logic [31:0]                       bram_read_data,
  input  logic                              bram_complete,
  output logic                              blk_valid,
  input  logic                              blk_ready,
  output logic [WORD_W*WORDS_PER_BLOCK-1:0] blk_data,
  output logic                              busy,
  output logic                              err_timeout
);

  localparam int               IDX_W    = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] word_idx;
  logic             wd_clear;
  logic             wd_enable;
  logic             wd_expired;

  // Handshake outputs are pure decodes of the state register, so a reset drops them at once.
  assign cmd_ready       = (state == ST_IDLE);
  assign busy            = (state != ST_IDLE);
  assign bram_start_read = (state == ST_REQ);
  assign blk_valid       = (state == ST_DONE);

  assign wd_enable = (state == ST_REQ) || (state == ST_REL);
  assign wd_clear  = (state_nx != state);

  bram_hs_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .axi_clk (axi_clk),
    .axi_rst (axi_rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (cmd_valid) state_nx = ST_REQ;
      ST_REQ: begin
        if (bram_complete)   state_nx = ST_REL;
        else if (wd_expired) state_nx = ST_ABORT;
      end
      // A new request only follows once the responder has released complete.
      ST_REL: begin
        if (!bram_complete)  state_nx = (word_idx == LAST_IDX) ? ST_DONE : ST_REQ;
        else if (wd_expired) state_nx = ST_ABORT;
      end
      ST_DONE:  if (blk_ready) state_nx = ST_IDLE;
      ST_ABORT: if (!bram_complete) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      state       <= ST_IDLE;
      word_idx    <= '0;
      bram_addr   <= '0;
      blk_data    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            bram_addr   <= cmd_base_addr;
            word_idx    <= '0;
            err_timeout <= 1'b0;
          end
        end
        ST_REQ: begin
          if (bram_complete) begin
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
              if (word_idx == IDX_W'(i)) begin
                blk_data[WORD_W*(WORDS_PER_BLOCK-1-i) +: WORD_W] <= bram_read_data;
              end
            end
          end else if (wd_expired) begin
            err_timeout <= 1'b1;
          end
        end
        ST_REL: begin
          if (!bram_complete) begin
            if (word_idx != LAST_IDX) begin
              word_idx  <= word_idx + IDX_W'(1);
              bram_addr <= bram_addr + 32'(ADDR_STRIDE);
            end
          end else if (wd_expired) begin
            err_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_bram_block_reader.sv
// Self-checking bench for aes_bram_block_reader: behavioural BRAM responder plus
// address and block scoreboards filled when commands are issued.
module tb_aes_bram_block_reader;

  localparam int TO = 16;

  logic         axi_clk;
  logic         axi_rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [31:0]  cmd_base_addr;
  logic         bram_start_read;
  logic [31:0]  bram_addr;
  logic [31:0]  bram_read_data;
  logic         bram_complete;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] blk_data;
  logic         busy;
  logic         err_timeout;

  int checks = 0;
  int errors = 0;

  logic [31:0]  exp_addr_q[$];
  logic [127:0] exp_blk_q[$];

  int lat          = 2;
  int hold         = 0;
  int stall_at     = -1;
  int resp_idx     = 0;
  int stall_cycles = 0;
  int resp_wait    = 0;
  bit saw_valid    = 0;

  logic [31:0]  resp_addr;
  logic [31:0]  resp_exp;
  logic         prev_start = 1'b0;
  logic [31:0]  prev_addr  = '0;
  logic [127:0] mon_exp;

  aes_bram_block_reader #(
    .WORDS_PER_BLOCK (4),
    .ADDR_STRIDE     (4),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .axi_clk         (axi_clk),
    .axi_rst         (axi_rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_base_addr   (cmd_base_addr),
    .bram_start_read (bram_start_read),
    .bram_addr       (bram_addr),
    .bram_read_data  (bram_read_data),
    .bram_complete   (bram_complete),
    .blk_valid       (blk_valid),
    .blk_ready       (blk_ready),
    .blk_data        (blk_data),
    .busy            (busy),
    .err_timeout     (err_timeout)
  );

  initial begin
    axi_clk = 1'b0;
    forever #5 axi_clk = ~axi_clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h0011_2233;
      32'h0000_0014: return 32'h4455_6677;
      32'h0000_0018: return 32'h8899_AABB;
      32'h0000_001C: return 32'hCCDD_EEFF;
      default:       return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Behavioural BRAM responder: answers each request after lat cycles, holds complete for hold cycles.
  initial begin
    bram_complete  = 1'b0;
    bram_read_data = '0;
    forever begin
      @(negedge axi_clk);
      if (axi_rst && bram_start_read && !bram_complete) begin
        resp_addr = bram_addr;
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL req_addr: got request at %h, none expected", resp_addr);
        end else begin
          resp_exp = exp_addr_q.pop_front();
          if (resp_addr !== resp_exp) begin
            errors++;
            $display("[TB] FAIL req_addr: got %h, expected %h", resp_addr, resp_exp);
          end
        end
        if (resp_idx == stall_at) begin
          stall_cycles = 0;
          while (bram_start_read && axi_rst && stall_cycles < 200) begin
            stall_cycles++;
            @(negedge axi_clk);
          end
        end else begin
          repeat (lat - 1) @(negedge axi_clk);
          if (bram_start_read && axi_rst) begin
            bram_read_data = mem_word(resp_addr);
            bram_complete  = 1'b1;
            resp_wait      = 0;
            while (bram_start_read && resp_wait < 200) begin
              resp_wait++;
              @(negedge axi_clk);
            end
            repeat (hold) @(negedge axi_clk);
            bram_complete = 1'b0;
          end
        end
        resp_idx++;
      end
    end
  end

  // Protocol and block monitor, sampling mid-cycle after the drivers have settled.
  initial begin
    forever begin
      @(negedge axi_clk);
      #1;
      if (bram_start_read && !prev_start) begin
        checks++;
        if (bram_complete !== 1'b0) begin
          errors++;
          $display("[TB] FAIL req_overlap: start_read rose with complete=%b, expected 0", bram_complete);
        end
      end
      if (bram_start_read && prev_start) begin
        checks++;
        if (bram_addr !== prev_addr) begin
          errors++;
          $display("[TB] FAIL addr_stable: got %h, expected %h", bram_addr, prev_addr);
        end
      end
      if (blk_valid) saw_valid = 1'b1;
      if (blk_valid && blk_ready) begin
        checks++;
        if (exp_blk_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL blk_out: got block %h, none expected", blk_data);
        end else begin
          mon_exp = exp_blk_q.pop_front();
          if (blk_data !== mon_exp) begin
            errors++;
            $display("[TB] FAIL blk_out: got %h, expected %h", blk_data, mon_exp);
          end
        end
      end
      prev_start = bram_start_read;
      prev_addr  = bram_addr;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  task automatic issue_cmd(input logic [31:0] base, input int n_addr, input bit push_blk);
    int w;
    logic [127:0] blk;
    w = 0;
    @(negedge axi_clk);
    while (!cmd_ready && w < 2000) begin
      @(negedge axi_clk);
      w++;
    end
    checks++;
    if (w >= 2000) begin
      errors++;
      $display("[TB] FAIL cmd_ready_wait: got cmd_ready=%b, expected 1", cmd_ready);
    end
    resp_idx = 0;
    for (int i = 0; i < n_addr; i++) exp_addr_q.push_back(base + 32'(i * 4));
    if (push_blk) begin
      for (int i = 0; i < 4; i++) blk[127 - 32*i -: 32] = mem_word(base + 32'(i * 4));
      exp_blk_q.push_back(blk);
    end
    cmd_valid     = 1'b1;
    cmd_base_addr = base;
    @(negedge axi_clk);
    cmd_valid     = 1'b0;
    cmd_base_addr = 32'hDEAD_BEEF;
  endtask

  task automatic wait_drained(input int bound);
    int w;
    w = 0;
    while ((exp_blk_q.size() != 0 || !cmd_ready) && w < bound) begin
      @(negedge axi_clk);
      #1;
      w++;
    end
    checks++;
    if (w >= bound) begin
      errors++;
      $display("[TB] FAIL drain: got %0d blocks pending, expected 0", exp_blk_q.size());
    end
  endtask

  task automatic test_reset();
    axi_rst       = 1'b0;
    cmd_valid     = 1'b0;
    cmd_base_addr = '0;
    blk_ready     = 1'b0;
    repeat (3) @(negedge axi_clk);
    #1;
    checks++;
    if ({cmd_ready, busy, bram_start_read, blk_valid, err_timeout} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 10000",
               {cmd_ready, busy, bram_start_read, blk_valid, err_timeout});
    end
    checks++;
    if (blk_data !== '0 || bram_addr !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h/%h, expected 0/0", blk_data, bram_addr);
    end
    @(negedge axi_clk);
    axi_rst = 1'b1;
    @(negedge axi_clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got ready=%b busy=%b, expected 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic();
    lat = 2; hold = 0; blk_ready = 1'b1;
    issue_cmd(32'h0000_0010, 4, 1'b1);
    #1;
    checks++;
    if (bram_start_read !== 1'b1 || bram_addr !== 32'h10 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_req: got start=%b addr=%h busy=%b ready=%b, expected 1/00000010/1/0",
               bram_start_read, bram_addr, busy, cmd_ready);
    end
    wait_drained(300);
    checks++;
    if (blk_data !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin
      errors++;
      $display("[TB] FAIL basic_block: got %h, expected 00112233445566778899aabbccddeeff", blk_data);
    end
    checks++;
    if (err_timeout !== 1'b0 || exp_addr_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL basic_status: got err=%b pending=%0d, expected 0/0", err_timeout, exp_addr_q.size());
    end
  endtask

  task automatic test_backpressure();
    int w;
    logic [127:0] exp;
    blk_ready = 1'b0;
    issue_cmd(32'h0000_0010, 4, 1'b1);
    exp = exp_blk_q[0];
    w = 0;
    while (!blk_valid && w < 300) begin
      @(negedge axi_clk);
      #1;
      w++;
    end
    checks++;
    if (w >= 300) begin
      errors++;
      $display("[TB] FAIL bp_valid_wait: got blk_valid=%b, expected 1", blk_valid);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge axi_clk);
      #1;
      checks++;
      if (blk_valid !== 1'b1 || blk_data !== exp || cmd_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold: got valid=%b ready=%b data=%h, expected 1/0/%h",
                 blk_valid, cmd_ready, blk_data, exp);
      end
    end
    @(negedge axi_clk);
    blk_ready = 1'b1;
    @(negedge axi_clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || blk_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release: got ready=%b valid=%b, expected 1/0", cmd_ready, blk_valid);
    end
  endtask

  task automatic test_wrap();
    issue_cmd(32'hFFFF_FFF8, 4, 1'b1);
    wait_drained(300);
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL wrap_addrs: got %0d addresses not requested, expected 0", exp_addr_q.size());
    end
  endtask

  task automatic test_timeout();
    int w;
    stall_at  = 2;
    saw_valid = 1'b0;
    issue_cmd(32'h0000_0300, 3, 1'b0);
    w = 0;
    while (!err_timeout && w < 300) begin
      @(negedge axi_clk);
      #1;
      w++;
    end
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_flag: got err=%b, expected 1", err_timeout);
    end
    checks++;
    if (stall_cycles != TO) begin
      errors++;
      $display("[TB] FAIL timeout_len: got %0d cycles in REQ, expected %0d", stall_cycles, TO);
    end
    checks++;
    if (bram_start_read !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_start: got start=%b, expected 0", bram_start_read);
    end
    repeat (3) @(negedge axi_clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || err_timeout !== 1'b1 || saw_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_idle: got ready=%b err=%b saw_valid=%b, expected 1/1/0",
               cmd_ready, err_timeout, saw_valid);
    end
    stall_at = -1;
    issue_cmd(32'h0000_0020, 4, 1'b1);
    #1;
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_clear: got err=%b, expected 0", err_timeout);
    end
    wait_drained(300);
  endtask

  task automatic test_reset_mid();
    int w;
    issue_cmd(32'h0000_0040, 4, 1'b1);
    w = 0;
    while (!(bram_start_read && bram_addr == 32'h44) && w < 300) begin
      @(negedge axi_clk);
      #1;
      w++;
    end
    checks++;
    if (w >= 300) begin
      errors++;
      $display("[TB] FAIL rst_mid_wait: got addr=%h, expected 00000044", bram_addr);
    end
    axi_rst = 1'b0;
    #1;
    checks++;
    if ({bram_start_read, busy, cmd_ready, blk_valid} !== 4'b0010 || blk_data !== '0 || bram_addr !== '0) begin
      errors++;
      $display("[TB] FAIL rst_mid: got ctrl=%b data=%h addr=%h, expected 0010/0/0",
               {bram_start_read, busy, cmd_ready, blk_valid}, blk_data, bram_addr);
    end
    repeat (5) @(negedge axi_clk);
    exp_addr_q.delete();
    exp_blk_q.delete();
    axi_rst = 1'b1;
    issue_cmd(32'h0000_0080, 4, 1'b1);
    wait_drained(300);
  endtask

  task automatic test_back_to_back();
    hold = 5;
    issue_cmd(32'h0000_0100, 4, 1'b1);
    issue_cmd(32'h0000_0200, 4, 1'b1);
    wait_drained(600);
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_addrs: got %0d addresses not requested, expected 0", exp_addr_q.size());
    end
    hold = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (5) @(negedge axi_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_bram_block_reader.md
Name: aes_bram_block_reader

Overview:
Requester-side engine for the BRAM interface's read handshake (start_read / bram_complete four-phase protocol). It accepts one command carrying a base byte address and issues WORDS_PER_BLOCK sequential word reads. It assembles the returned words into one 128-bit AES block and presents that block on a valid/ready output to the AES datapath. A watchdog aborts any handshake phase the BRAM interface fails to complete.

Parameters:
WORDS_PER_BLOCK, 4, words fetched per command; block width = 32*WORDS_PER_BLOCK (128 at default).
ADDR_STRIDE, 4, byte increment between consecutive word reads.
TIMEOUT_CYCLES, 1023, cycles allowed in any single handshake phase before abort.

Ports:
axi_clk  in  1  sole clock; all logic on rising edge.
axi_rst  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready.
cmd_base_addr  in  32  byte address of word 0; sampled on acceptance.
bram_start_read  out  1  read request to the BRAM interface.
bram_addr  out  32  read address; stable for the whole time bram_start_read is high.
bram_read_data  in  32  read data; valid when bram_complete is high.
bram_complete  in  1  transaction-done indication from the BRAM interface.
blk_valid  out  1  assembled block available.
blk_ready  in  1  downstream accepts block.
blk_data  out  128  assembled block; word 0 at [127:96], word 3 at [31:0].
busy  out  1  high in any state other than IDLE.
err_timeout  out  1  sticky abort flag; cleared on next command acceptance.

Behaviour:
- Reset (axi_rst=0, asynchronous): state=IDLE; word index=0; all outputs 0 except cmd_ready=1; blk_data=0; watchdog=0. Reset mid-handshake drops bram_start_read immediately, without waiting for bram_complete.
- States: IDLE, REQ, REL, DONE, ABORT.
- IDLE: on accept, latch base address, set word index=0, clear err_timeout, go to REQ. bram_addr=base is driven in the same edge that raises bram_start_read.
- REQ: bram_start_read=1, bram_addr=base+index*ADDR_STRIDE (32-bit modular; wraps past 0xFFFFFFFF). On the first rising edge sampling bram_complete=1: capture bram_read_data into the word slot for index, drop bram_start_read, go to REL.
- REL: bram_start_read=0; wait for bram_complete=0, which is the four-phase release. Then: if index==WORDS_PER_BLOCK-1 go to DONE; else increment index and go to REQ. A new request is never raised while bram_complete is still high.
- DONE: blk_valid=1; blk_data held stable until blk_ready. On blk_valid & blk_ready go to IDLE next cycle. cmd_ready stays low in DONE, so a new command cannot overlap the handoff.
- Watchdog: counter resets on every state entry and counts while in REQ or REL. On reaching TIMEOUT_CYCLES: set err_timeout=1, drop bram_start_read, discard the partial block (blk_valid never asserted), go to ABORT.
- ABORT: wait for bram_complete=0, then go to IDLE. err_timeout stays high until the next accepted command.
- Latency, responder latency L cycles per word: the first request rises 1 cycle after acceptance. Each word costs L + release time + 1. blk_valid rises 1 cycle after the final release.
- bram_complete already high on REQ entry: this cannot occur legally, because REL guarantees it is low.
- Spurious bram_complete in IDLE or DONE is ignored.
- Outputs are registered; no combinational path from any input to any output except none (cmd_ready is decoded from state only).

Decomposition:
- Shared package aes_bram_pkg holds:
  - WORD_W=32, BLOCK_W=128;
  - the state enum encoding (IDLE=0, REQ=1, REL=2, DONE=3, ABORT=4);
  - default ADDR_STRIDE.
- The same package is reused by the future block-writer counterpart.
- One natural sub-module, bram_hs_watchdog: a loadable up-counter with clear and terminal-count output, parameterised by TIMEOUT_CYCLES.
- Everything else lives in the top-level FSM.

Test Plan:
1. Base 0x00000010, responder latency 2, memory words 0x00112233/0x44556677/0x8899AABB/0xCCDDEEFF at 0x10..0x1C -> addresses 0x10, 0x14, 0x18, 0x1C issued in order; blk_data=0x00112233_44556677_8899AABB_CCDDEEFF; err_timeout=0.
2. Same as 1 with blk_ready held low 20 cycles -> blk_valid stays 1, blk_data unchanged, cmd_ready=0 throughout; IDLE one cycle after blk_ready=1.
3. Base 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
4. Responder never asserts bram_complete on word 2, TIMEOUT_CYCLES=16 -> err_timeout=1 after 16 cycles in REQ; bram_start_read=0; blk_valid never 1; next command clears err_timeout and completes normally.
5. axi_rst pulsed low while in REQ of word 1 -> all outputs reset within the same cycle, bram_start_read=0; a fresh command after release fetches a full correct block.
6. Responder holds bram_complete high 5 cycles after start drops -> no new bram_start_read until complete falls; back-to-back commands produce two correct blocks with no protocol overlap.
